// File: rtl/led_arb_pkg.sv
// Shared types and sizing helpers for the LED bank arbiter.
package led_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int CNT_W = 32;

  function automatic int owner_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_bank_arbiter_if.sv
// Request bundle between the LED pattern sources and the arbiter.
interface led_bank_arbiter_if #(
  parameter int NUM_REQ   = 3,
  parameter int LED_WIDTH = 10
);
  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0][LED_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                req_ready;

  modport master (output req_valid, output req_data, input req_ready);
  modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/led_bank_arbiter_rr_priority_picker.sv
// Rotating-priority encoder: first set request strictly after ptr, wrapping.
module rr_priority_picker
  import led_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  localparam int OW     = owner_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OW-1:0]      ptr,
  output logic [OW-1:0]      winner,
  output logic               any_req
);

  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    // Scan from farthest to nearest so the nearest set bit is the last write.
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) winner = OW'(idx);
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the board LED bank with a minimum display time per grant.
module led_bank_arbiter
  import led_arb_pkg::*;
#(
  parameter int          NUM_REQ     = 3,
  parameter int          LED_WIDTH   = 10,
  parameter logic [31:0] HOLD_CYCLES = 32'd50_000_000,
  localparam int         OW          = owner_w(NUM_REQ)
) (
  input  logic                 in_clk,
  input  logic                 in_reset,
  led_bank_arbiter_if.slave    req,
  output logic [LED_WIDTH-1:0] out_led,
  output logic [OW-1:0]        out_owner,
  output logic                 out_busy
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [OW-1:0]      ptr, ptr_nxt;
  logic [OW-1:0]      owner_nxt;
  logic [LED_WIDTH-1:0] led_nxt;
  logic [NUM_REQ-1:0] ready, ready_nxt;
  logic               busy_nxt;
  logic [OW-1:0]      winner;
  logic               any_req;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (req.req_valid),
    .ptr     (ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= OW'(NUM_REQ - 1);
      out_led   <= '0;
      out_owner <= '0;
      ready     <= '0;
      out_busy  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ptr       <= ptr_nxt;
      out_led   <= led_nxt;
      out_owner <= owner_nxt;
      ready     <= ready_nxt;
      out_busy  <= busy_nxt;
    end
  end

  // The counter is loaded on the grant edge, so the GRANT cycle is the first
  // of HOLD_CYCLES busy cycles and IDLE returns HOLD_CYCLES cycles later.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    led_nxt   = out_led;
    owner_nxt = out_owner;
    ready_nxt = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          led_nxt           = req.req_data[winner];
          owner_nxt         = winner;
          ptr_nxt           = winner;
          cnt_nxt           = HOLD_CYCLES - 32'd1;
          ready_nxt[winner] = 1'b1;
          state_nxt         = GRANT;
        end
      end
      GRANT, HOLD: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt   = cnt - 32'd1;
          state_nxt = HOLD;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  assign req.req_ready = ready;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed bench for led_bank_arbiter with NUM_REQ=3, LED_WIDTH=10, HOLD_CYCLES=4.
module tb_led_bank_arbiter;

  logic       in_clk = 1'b0;
  logic       in_reset;
  logic [9:0] out_led;
  logic [0:0] out_owner;
  logic [1:0] owner_wide;
  logic       out_busy;
  int         n_assert = 0;
  int         n_fail   = 0;

  always #5 in_clk = ~in_clk;

  led_bank_arbiter_if #(.NUM_REQ(3), .LED_WIDTH(10)) bus ();

  led_bank_arbiter #(.NUM_REQ(3), .LED_WIDTH(10), .HOLD_CYCLES(32'd4)) dut (
    .in_clk    (in_clk),
    .in_reset  (in_reset),
    .req       (bus),
    .out_led   (out_led),
    .out_owner (owner_wide),
    .out_busy  (out_busy)
  );

  assign out_owner = owner_wide[0];

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [9:0] led, input logic [2:0] rdy,
                         input logic [1:0] own, input logic busy);
    chk({tag, ".led"},   32'(out_led),       32'(led));
    chk({tag, ".ready"}, 32'(bus.req_ready), 32'(rdy));
    chk({tag, ".owner"}, 32'(owner_wide),    32'(own));
    chk({tag, ".busy"},  32'(out_busy),      32'(busy));
  endtask

  initial begin
    in_reset      = 1'b1;
    bus.req_valid = 3'b000;
    bus.req_data  = '0;
    tick(); tick();
    chk_out("reset", 10'h000, 3'b000, 2'd0, 1'b0);
    in_reset = 1'b0;

    // Single request: grant in N+1, busy N+1..N+4, idle in N+5.
    bus.req_valid   = 3'b001;
    bus.req_data[0] = 10'h155;
    tick();
    chk_out("single.grant", 10'h155, 3'b001, 2'd0, 1'b1);
    bus.req_valid = 3'b000;
    tick(); chk_out("single.h1", 10'h155, 3'b000, 2'd0, 1'b1);
    tick(); chk_out("single.h2", 10'h155, 3'b000, 2'd0, 1'b1);
    tick(); chk_out("single.h3", 10'h155, 3'b000, 2'd0, 1'b1);
    tick(); chk_out("single.idle", 10'h155, 3'b000, 2'd0, 1'b0);

    // All three held continuously from reset: grants 0,1,2,0 every 5 cycles.
    bus.req_valid   = 3'b111;
    bus.req_data[0] = 10'h001;
    bus.req_data[1] = 10'h002;
    bus.req_data[2] = 10'h004;
    in_reset = 1'b1;
    tick();
    in_reset = 1'b0;
    tick();
    chk_out("all.g0", 10'h001, 3'b001, 2'd0, 1'b1);
    for (int t = 1; t <= 4; t++) begin
      tick();
      chk("all.g0.busy", 32'(out_busy), 32'(t < 4));
    end
    tick();
    chk_out("all.g1", 10'h002, 3'b010, 2'd1, 1'b1);
    for (int t = 1; t <= 4; t++) begin
      tick();
      chk("all.g1.ready", 32'(bus.req_ready), 32'd0);
    end
    tick();
    chk_out("all.g2", 10'h004, 3'b100, 2'd2, 1'b1);
    tick(); tick(); tick(); tick();
    tick();
    chk_out("all.g3", 10'h001, 3'b001, 2'd0, 1'b1);
    bus.req_valid = 3'b000;

    // Wrap and fairness: after granting 2, a 101 request goes to 0 first.
    tick(); tick(); tick(); tick();
    bus.req_valid   = 3'b100;
    bus.req_data[2] = 10'h0AA;
    tick();
    chk_out("wrap.g2", 10'h0AA, 3'b100, 2'd2, 1'b1);
    bus.req_valid   = 3'b101;
    bus.req_data[0] = 10'h0F0;
    tick(); tick(); tick(); tick();
    tick();
    chk_out("wrap.g0", 10'h0F0, 3'b001, 2'd0, 1'b1);
    bus.req_valid = 3'b100;
    tick(); tick(); tick(); tick();
    tick();
    chk_out("wrap.g2b", 10'h0AA, 3'b100, 2'd2, 1'b1);
    bus.req_valid = 3'b000;

    // Request during hold waits for the IDLE cycle.
    tick(); tick(); tick(); tick();
    bus.req_valid   = 3'b001;
    bus.req_data[0] = 10'h111;
    tick();
    chk_out("dur.g0", 10'h111, 3'b001, 2'd0, 1'b1);
    bus.req_valid = 3'b000;
    tick();
    bus.req_valid   = 3'b010;
    bus.req_data[1] = 10'h3FF;
    tick(); chk_out("dur.h2", 10'h111, 3'b000, 2'd0, 1'b1);
    tick(); chk_out("dur.h3", 10'h111, 3'b000, 2'd0, 1'b1);
    tick(); chk_out("dur.idle", 10'h111, 3'b000, 2'd0, 1'b0);
    tick(); chk_out("dur.g1", 10'h3FF, 3'b010, 2'd1, 1'b1);
    bus.req_valid = 3'b000;

    // Reset at hold count 2, then a pending 010 is the first arbitration.
    tick();
    in_reset        = 1'b1;
    bus.req_valid   = 3'b010;
    bus.req_data[1] = 10'h2A5;
    tick();
    chk_out("rst.mid", 10'h000, 3'b000, 2'd0, 1'b0);
    in_reset = 1'b0;
    tick();
    chk_out("rst.g1", 10'h2A5, 3'b010, 2'd1, 1'b1);
    bus.req_valid = 3'b000;

    // Transient valid during hold is never seen; late data change ignored.
    tick(); tick(); tick(); tick();
    bus.req_valid   = 3'b001;
    bus.req_data[0] = 10'h0C3;
    tick();
    chk_out("late.g0", 10'h0C3, 3'b001, 2'd0, 1'b1);
    bus.req_valid   = 3'b000;
    bus.req_data[0] = 10'h3C0;
    tick();
    bus.req_valid   = 3'b100;
    bus.req_data[2] = 10'h155;
    tick(); chk_out("late.h2", 10'h0C3, 3'b000, 2'd0, 1'b1);
    bus.req_valid = 3'b000;
    tick(); chk_out("late.h3", 10'h0C3, 3'b000, 2'd0, 1'b1);
    tick(); chk_out("late.idle", 10'h0C3, 3'b000, 2'd0, 1'b0);
    tick(); chk_out("late.idle2", 10'h0C3, 3'b000, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
